// File: rtl/result_scheduler_if.sv
// Bundle of requester-side and engine-side signals of the result scheduler.
// The scheduler uses the slave view; requesters and the engine use the master view.
interface result_scheduler_if;
  // requester side
  logic        req0;
  logic        req1;
  logic [3:0]  addr0;
  logic [3:0]  addr1;
  logic        ack0;
  logic        ack1;
  logic        done0;
  logic        done1;
  logic        err;
  logic [15:0] res_out;
  logic [3:0]  res_dout;
  logic        busy;
  // engine side
  logic        eng_start;
  logic [3:0]  eng_addr;
  logic        eng_rst;
  logic [15:0] eng_out;
  logic [3:0]  eng_dout;
  logic        eng_finish;

  modport slave (
    input  req0, req1, addr0, addr1, eng_out, eng_dout, eng_finish,
    output ack0, ack1, done0, done1, err, res_out, res_dout, busy,
           eng_start, eng_addr, eng_rst
  );

  modport master (
    output req0, req1, addr0, addr1, eng_out, eng_dout, eng_finish,
    input  ack0, ack1, done0, done1, err, res_out, res_dout, busy,
           eng_start, eng_addr, eng_rst
  );
endinterface

// File: rtl/result_scheduler.sv
// Two-requester round-robin scheduler for the result memory-walk engine.
// Launches one job at a time, waits for a rising edge of the engine finish,
// returns the captured results and aborts hung jobs with a watchdog.
module result_scheduler #(
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  result_scheduler_if.slave bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RECOVER} state_t;

  state_t        state_reg;
  logic          last_reg;      // requester served most recently
  logic          grant_reg;     // requester owning the current job
  logic          fin_q_reg;     // previous-cycle copy of eng_finish
  logic [CW-1:0] cnt_reg;       // watchdog counter, saturates at CNT_MAX

  logic          ack0_reg, ack1_reg, done0_reg, done1_reg, err_reg;
  logic          busy_reg, eng_start_reg;
  logic [3:0]    eng_addr_reg;
  logic [15:0]   res_out_reg;
  logic [3:0]    res_dout_reg;

  logic          fin_rise;
  logic          pick1;

  // A finish level left over from an earlier job never counts as completion.
  assign fin_rise = bus.eng_finish & ~fin_q_reg;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1 = bus.req1 & (~bus.req0 | ~last_reg);

  // Scheduler state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      grant_reg     <= 1'b0;
      fin_q_reg     <= 1'b0;
      cnt_reg       <= '0;
      ack0_reg      <= 1'b0;
      ack1_reg      <= 1'b0;
      done0_reg     <= 1'b0;
      done1_reg     <= 1'b0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      eng_start_reg <= 1'b0;
      eng_addr_reg  <= 4'h0;
      res_out_reg   <= 16'h0000;
      res_dout_reg  <= 4'h0;
    end else begin
      // pulse outputs default low so each lasts exactly one cycle
      ack0_reg      <= 1'b0;
      ack1_reg      <= 1'b0;
      done0_reg     <= 1'b0;
      done1_reg     <= 1'b0;
      err_reg       <= 1'b0;
      eng_start_reg <= 1'b0;
      // finish is tracked in every state; the engine reset clears it
      fin_q_reg     <= (state_reg == RECOVER) ? 1'b0 : bus.eng_finish;

      case (state_reg)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            grant_reg     <= pick1;
            eng_addr_reg  <= pick1 ? bus.addr1 : bus.addr0;
            ack0_reg      <= ~pick1;
            ack1_reg      <= pick1;
            eng_start_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= LAUNCH;
          end
        end

        LAUNCH: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end

        WAIT: begin
          if (fin_rise) begin
            // completion takes priority over a simultaneous timeout
            res_out_reg  <= bus.eng_out;
            res_dout_reg <= bus.eng_dout;
            done0_reg    <= ~grant_reg;
            done1_reg    <= grant_reg;
            last_reg     <= grant_reg;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end else if (cnt_reg == CNT_MAX) begin
            done0_reg <= ~grant_reg;
            done1_reg <= grant_reg;
            err_reg   <= 1'b1;
            last_reg  <= grant_reg;
            state_reg <= RECOVER;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        RECOVER: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Engine reset follows the scheduler reset and covers the recovery cycle.
  assign bus.eng_rst   = rst | (state_reg == RECOVER);

  assign bus.ack0      = ack0_reg;
  assign bus.ack1      = ack1_reg;
  assign bus.done0     = done0_reg;
  assign bus.done1     = done1_reg;
  assign bus.err       = err_reg;
  assign bus.busy      = busy_reg;
  assign bus.eng_start = eng_start_reg;
  assign bus.eng_addr  = eng_addr_reg;
  assign bus.res_out   = res_out_reg;
  assign bus.res_dout  = res_dout_reg;

endmodule

// File: tb/tb_result_scheduler.sv
// Directed bench for result_scheduler: single job, stale finish, timeout,
// completion/timeout tie, reset mid-job and round-robin arbitration.
module tb_result_scheduler;

  localparam int TO = 15;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // start/done bookkeeping from the monitor
  int   starts = 0;
  bit   outstanding = 0;
  bit   double_start = 0;
  bit   mon_en = 1;

  result_scheduler_if bus ();

  result_scheduler #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count launches and flag a second start before the previous job ended.
  always @(negedge clk) begin
    if (!mon_en) outstanding = 0;
    if (bus.eng_start) begin
      starts++;
      if (outstanding) double_start = 1;
      outstanding = 1;
    end
    if (bus.done0 | bus.done1) outstanding = 0;
  end

  // One job from a single requester; the engine raises finish at negedge
  // fin_at after the LAUNCH cycle (0 = never) and drops it at drop_at.
  task automatic job(input int who, input logic [3:0] a, input int fin_at, input int drop_at,
                     input logic [15:0] o, input logic [3:0] d, input bit exp_err,
                     input logic [15:0] eo, input logic [3:0] ed);
    int done_at;
    bit early;
    done_at = exp_err ? TO + 2 : fin_at + 1;
    early = 0;
    @(negedge clk);
    if (who == 0) begin bus.req0 = 1'b1; bus.addr0 = a; end
    else begin bus.req1 = 1'b1; bus.addr1 = a; end
    @(negedge clk);
    check("ack", (who == 0) ? bus.ack0 : bus.ack1, 1);
    check("ack_other", (who == 0) ? bus.ack1 : bus.ack0, 0);
    check("eng_start", bus.eng_start, 1);
    check("eng_addr", bus.eng_addr, a);
    check("busy_launch", bus.busy, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int k = 1; k < done_at; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("start_pulse", bus.eng_start, 0);
        check("ack_pulse", bus.ack0 | bus.ack1, 0);
      end
      if (bus.done0 | bus.done1 | bus.err) early = 1;
      if (k == drop_at) bus.eng_finish = 1'b0;
      if (k == fin_at) begin
        bus.eng_finish = 1'b1;
        bus.eng_out    = o;
        bus.eng_dout   = d;
      end
    end
    @(negedge clk);
    check("early_done", early, 0);
    check("done", (who == 0) ? bus.done0 : bus.done1, 1);
    check("done_other", (who == 0) ? bus.done1 : bus.done0, 0);
    check("err", bus.err, exp_err);
    check("res_out", bus.res_out, eo);
    check("res_dout", bus.res_dout, ed);
    if (exp_err) begin
      check("eng_rst_recover", bus.eng_rst, 1);
      @(negedge clk);
      check("eng_rst_after", bus.eng_rst, 0);
      check("err_pulse", bus.err, 0);
    end
    check("busy_idle", bus.busy, 0);
    $display("job req%0d addr=%0h err=%0b res_out=%0h res_dout=%0h", who, a, bus.err | exp_err,
             bus.res_out, bus.res_dout);
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.addr0 = 4'h0;
    bus.addr1 = 4'h0;
    bus.eng_out = 16'h0;
    bus.eng_dout = 4'h0;
    bus.eng_finish = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_eng_rst", bus.eng_rst, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_res_out", bus.res_out, 0);
    check("rst_res_dout", bus.res_dout, 0);
    check("rst_eng_addr", bus.eng_addr, 0);
    check("rst_pulses", {bus.ack0, bus.ack1, bus.done0, bus.done1, bus.err, bus.eng_start}, 0);
    rst = 1'b0;
    #1;
    check("rst_release", bus.eng_rst, 0);

    // single job; finish is left high afterwards
    job(0, 4'h0, 12, 0, 16'd1234, 4'hA, 0, 16'd1234, 4'hA);

    // stale finish: dropped 2 cycles after start, raised again later
    job(1, 4'h5, 5, 2, 16'hBEEF, 4'h3, 0, 16'hBEEF, 4'h3);
    bus.eng_finish = 1'b0;

    // timeout: engine never finishes, results held
    job(1, 4'h9, 0, 0, 16'h0, 4'h0, 1, 16'hBEEF, 4'h3);

    // normal job right after the recovery
    job(0, 4'h2, 3, 0, 16'h0042, 4'h5, 0, 16'h0042, 4'h5);
    bus.eng_finish = 1'b0;

    // finish edge exactly when the counter reaches TIMEOUT
    job(1, 4'hC, TO + 1, 0, 16'h7777, 4'h9, 0, 16'h7777, 4'h9);
    bus.eng_finish = 1'b0;

    // reset in the middle of WAIT
    @(negedge clk);
    bus.req0 = 1'b1;
    bus.addr0 = 4'h6;
    @(negedge clk);
    check("mid_ack", bus.ack0, 1);
    bus.req0 = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    mon_en = 0;
    #1;
    check("mid_busy", bus.busy, 0);
    check("mid_eng_rst", bus.eng_rst, 1);
    check("mid_eng_addr", bus.eng_addr, 0);
    check("mid_res_out", bus.res_out, 0);
    #1 rst = 1'b0;
    begin
      bit seen_done;
      seen_done = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.done0 | bus.done1 | bus.busy) seen_done = 1;
      end
      check("mid_no_done", seen_done, 0);
    end
    mon_en = 1;
    job(1, 4'hE, 4, 0, 16'h1111, 4'h1, 0, 16'h1111, 4'h1);
    bus.eng_finish = 1'b0;

    // round robin: reset so requester 0 wins the first tie
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.addr0 = 4'h3;
    bus.addr1 = 4'h7;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = i % 2;
      @(negedge clk);
      check("rr_ack0", bus.ack0, (w == 0) ? 1 : 0);
      check("rr_ack1", bus.ack1, (w == 1) ? 1 : 0);
      check("rr_eng_addr", bus.eng_addr, (w == 1) ? 4'h7 : 4'h3);
      if (w == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      repeat (2) @(negedge clk);
      bus.eng_finish = 1'b1;
      bus.eng_out = 16'd100 + 16'(i);
      bus.eng_dout = 4'(i);
      @(negedge clk);
      check("rr_done", (w == 0) ? bus.done0 : bus.done1, 1);
      check("rr_res_out", bus.res_out, 16'd100 + 16'(i));
      bus.eng_finish = 1'b0;
      if (i < 3) begin
        if (w == 0) bus.req0 = 1'b1; else bus.req1 = 1'b1;
      end else begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      $display("rr job %0d granted req%0d eng_addr=%0h", i, w, (w == 1) ? 4'h7 : 4'h3);
    end
    repeat (3) @(negedge clk);
    check("no_double_start", double_start, 0);
    check("start_count", starts, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
